// File: rtl/snake_input_ctrl.sv
// Button debouncer, reversal-protected heading register and pause control for the snake game core.
// state     | meaning
// STABLE_LO | level 0 accepted, watching for a rise
// CHECK_HI  | input high, counting 1 ms ticks before accepting
// STABLE_HI | level 1 accepted, watching for a fall
// CHECK_LO  | input low, counting 1 ms ticks before accepting
module snake_input_ctrl #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter logic [1:0]  RESET_DIR   = 2'd3
) (
    input  logic       mclk,
    input  logic       clr,
    input  logic       tick1ms,
    input  logic       step_tick,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [1:0] cur_dir,
    output logic       step_out,
    output logic       paused
);

    typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} db_state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

    logic [4:0] sync1_q;
    logic [4:0] sync_q;
    db_state_t  db_q  [5];
    db_state_t  db_d  [5];
    logic [7:0] cnt_q [5];
    logic [7:0] cnt_d [5];
    logic [4:0] level_q, level_d;
    logic [4:0] press_q, press_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [1:0] pending_q, pending_d;
    logic       step_q, step_d;
    logic       paused_q, paused_d;

    logic       step_fire;
    logic       win_valid;
    logic [1:0] win_dir;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            db_d[i]    = db_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            press_d[i] = 1'b0;
            case (db_q[i])
                STABLE_LO: begin
                    if (sync_q[i]) begin
                        db_d[i]  = CHECK_HI;
                        cnt_d[i] = '0;
                    end
                end
                CHECK_HI: begin
                    if (!sync_q[i]) begin
                        db_d[i]  = STABLE_LO;
                        cnt_d[i] = '0;
                    end else if (tick1ms) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            db_d[i]    = STABLE_HI;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                STABLE_HI: begin
                    if (!sync_q[i]) begin
                        db_d[i]  = CHECK_LO;
                        cnt_d[i] = '0;
                    end
                end
                CHECK_LO: begin
                    if (sync_q[i]) begin
                        db_d[i]  = STABLE_HI;
                        cnt_d[i] = '0;
                    end else if (tick1ms) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            db_d[i]    = STABLE_LO;
                            cnt_d[i]   = '0;
                            level_d[i] = 1'b0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                default: begin
                    db_d[i]  = STABLE_LO;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // A press is judged against the heading that will be in force after this edge,
    // so a step and a press on the same cycle never let the snake reverse.
    always_comb begin
        step_fire = step_tick && !paused_q;
        cur_dir_d = step_fire ? pending_q : cur_dir_q;
        step_d    = step_fire;
        paused_d  = press_q[4] ? !paused_q : paused_q;

        win_valid = |press_q[3:0];
        if (press_q[0])      win_dir = 2'd0;
        else if (press_q[1]) win_dir = 2'd1;
        else if (press_q[2]) win_dir = 2'd2;
        else                 win_dir = 2'd3;

        pending_d = pending_q;
        if (win_valid && (win_dir != cur_dir_d) && (win_dir != (cur_dir_d ^ 2'b01)))
            pending_d = win_dir;
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            for (int i = 0; i < 5; i++) begin
                db_q[i]  <= STABLE_LO;
                cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            cur_dir_q <= RESET_DIR;
            pending_q <= RESET_DIR;
            step_q    <= 1'b0;
            paused_q  <= 1'b1;
        end else begin
            sync1_q   <= btn_raw;
            sync_q    <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                db_q[i]  <= db_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            cur_dir_q <= cur_dir_d;
            pending_q <= pending_d;
            step_q    <= step_d;
            paused_q  <= paused_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign cur_dir   = cur_dir_q;
    assign step_out  = step_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_MS=3 and a 1 ms tick every 10 cycles.
module tb_snake_input_ctrl;

    logic       mclk;
    logic       clr;
    logic       tick1ms;
    logic       step_tick;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [1:0] cur_dir;
    logic       step_out;
    logic       paused;

    int errors;
    int checks;

    snake_input_ctrl #(.DEBOUNCE_MS(3), .RESET_DIR(2'd3)) dut (
        .mclk      (mclk),
        .clr       (clr),
        .tick1ms   (tick1ms),
        .step_tick (step_tick),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .cur_dir   (cur_dir),
        .step_out  (step_out),
        .paused    (paused)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick1ms = 1'b1;
        @(posedge mclk);
        #1;
        tick1ms = 1'b0;
    endtask

    task automatic do_step();
        step_tick = 1'b1;
        @(posedge mclk);
        #1;
        step_tick = 1'b0;
    endtask

    // Drive a new raw pattern and let it settle: 2 sync edges, CHECK entry, then
    // three ticks; the final cycle (optionally with step_tick) consumes the press.
    task automatic set_btns(input logic [4:0] v, input bit with_step);
        btn_raw = v;
        idle(3);
        repeat (3) begin
            idle(9);
            pulse_tick();
        end
        step_tick = with_step;
        idle(1);
        step_tick = 1'b0;
    endtask

    task automatic do_reset();
        btn_raw   = '0;
        step_tick = 1'b0;
        tick1ms   = 1'b0;
        clr       = 1'b1;
        idle(2);
        clr       = 1'b0;
        idle(1);
    endtask

    task automatic unpause();
        set_btns(5'b10000, 1'b0);
        set_btns(5'b00000, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        clr = 1'b1;
        #1;
        checks++; if (btn_level !== 5'b0) begin errors++; $display("FAIL reset_level: got %b expected %b", btn_level, 5'b0); end
        checks++; if (btn_press !== 5'b0) begin errors++; $display("FAIL reset_press: got %b expected %b", btn_press, 5'b0); end
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL reset_dir: got %0d expected 3", cur_dir); end
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step_out); end
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL reset_paused: got %b expected 1", paused); end
        clr = 1'b0;
        idle(1);
    endtask

    task automatic test_debounce();
        do_reset();
        btn_raw = 5'b00001;
        idle(3);
        for (int k = 1; k <= 3; k++) begin
            idle(9);
            pulse_tick();
            checks++; if (btn_level[0] !== (k == 3)) begin errors++; $display("FAIL deb_level_tick%0d: got %b expected %b", k, btn_level[0], (k == 3)); end
            checks++; if (btn_press[0] !== (k == 3)) begin errors++; $display("FAIL deb_press_tick%0d: got %b expected %b", k, btn_press[0], (k == 3)); end
        end
        idle(1);
        checks++; if (btn_press !== 5'b0) begin errors++; $display("FAIL deb_press_width: got %b expected 00000", btn_press); end
        checks++; if (btn_level !== 5'b00001) begin errors++; $display("FAIL deb_level_hold: got %b expected 00001", btn_level); end
        btn_raw = 5'b0;
        idle(3);
        repeat (3) begin
            idle(9);
            pulse_tick();
        end
        checks++; if (btn_level !== 5'b0) begin errors++; $display("FAIL deb_release_level: got %b expected 00000", btn_level); end
        checks++; if (btn_press !== 5'b0) begin errors++; $display("FAIL deb_release_press: got %b expected 00000", btn_press); end
    endtask

    task automatic test_glitch();
        do_reset();
        btn_raw = 5'b00100;
        idle(3);
        repeat (2) begin
            idle(9);
            pulse_tick();
        end
        checks++; if (btn_level[2] !== 1'b0) begin errors++; $display("FAIL glitch_burst1: got %b expected 0", btn_level[2]); end
        btn_raw = 5'b0;
        idle(4);
        checks++; if (btn_level[2] !== 1'b0) begin errors++; $display("FAIL glitch_gap: got %b expected 0", btn_level[2]); end
        btn_raw = 5'b00100;
        idle(3);
        repeat (2) begin
            idle(9);
            pulse_tick();
        end
        checks++; if (btn_level[2] !== 1'b0) begin errors++; $display("FAIL glitch_cnt_cleared: got %b expected 0", btn_level[2]); end
        idle(9);
        pulse_tick();
        checks++; if (btn_level[2] !== 1'b1) begin errors++; $display("FAIL glitch_accept_level: got %b expected 1", btn_level[2]); end
        checks++; if (btn_press !== 5'b00100) begin errors++; $display("FAIL glitch_accept_press: got %b expected 00100", btn_press); end
    endtask

    task automatic test_reversal();
        do_reset();
        set_btns(5'b10000, 1'b0);
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL rev_unpause: got %b expected 0", paused); end
        set_btns(5'b00000, 1'b0);
        set_btns(5'b00100, 1'b0);
        do_step();
        checks++; if (step_out !== 1'b1) begin errors++; $display("FAIL rev_step_pulse: got %b expected 1", step_out); end
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL rev_dir: got %0d expected 3", cur_dir); end
        idle(1);
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL rev_step_width: got %b expected 0", step_out); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        unpause();
        set_btns(5'b00001, 1'b0);
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL same_pre_dir: got %0d expected 3", cur_dir); end
        set_btns(5'b00010, 1'b1);
        checks++; if (step_out !== 1'b1) begin errors++; $display("FAIL same_step: got %b expected 1", step_out); end
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL same_commit: got %0d expected 0", cur_dir); end
        do_step();
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL same_down_rejected: got %0d expected 0", cur_dir); end
        set_btns(5'b01000, 1'b0);
        do_step();
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL same_right_accepted: got %0d expected 3", cur_dir); end
    endtask

    task automatic test_priority_pause();
        do_reset();
        unpause();
        set_btns(5'b00101, 1'b0);
        do_step();
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL prio_up_wins: got %0d expected 0", cur_dir); end
        set_btns(5'b10101, 1'b0);
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %b expected 1", paused); end
        do_step();
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL pause_no_step: got %b expected 0", step_out); end
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL pause_dir_hold: got %0d expected 0", cur_dir); end
        set_btns(5'b01000, 1'b0);
        checks++; if (btn_level !== 5'b01000) begin errors++; $display("FAIL pause_level_visible: got %b expected 01000", btn_level); end
        set_btns(5'b11000, 1'b1);
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL resume: got %b expected 0", paused); end
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL resume_step_ignored: got %b expected 0", step_out); end
        checks++; if (cur_dir !== 2'd0) begin errors++; $display("FAIL resume_dir: got %0d expected 0", cur_dir); end
        do_step();
        checks++; if (step_out !== 1'b1) begin errors++; $display("FAIL resume_next_step: got %b expected 1", step_out); end
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL pause_press_kept: got %0d expected 3", cur_dir); end
    endtask

    task automatic test_async_reset();
        do_reset();
        unpause();
        set_btns(5'b00001, 1'b0);
        do_step();
        btn_raw = 5'b00011;
        idle(3);
        idle(9);
        pulse_tick();
        #2;
        clr = 1'b1;
        #1;
        checks++; if (cur_dir !== 2'd3) begin errors++; $display("FAIL async_dir: got %0d expected 3", cur_dir); end
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL async_paused: got %b expected 1", paused); end
        checks++; if (btn_level !== 5'b0) begin errors++; $display("FAIL async_level: got %b expected 00000", btn_level); end
        checks++; if (btn_press !== 5'b0) begin errors++; $display("FAIL async_press: got %b expected 00000", btn_press); end
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL async_step: got %b expected 0", step_out); end
        btn_raw = 5'b00010;
        idle(2);
        clr = 1'b0;
        idle(3);
        repeat (2) begin
            idle(9);
            pulse_tick();
        end
        checks++; if (btn_level !== 5'b0) begin errors++; $display("FAIL async_partial_discarded: got %b expected 00000", btn_level); end
        idle(9);
        pulse_tick();
        checks++; if (btn_level !== 5'b00010) begin errors++; $display("FAIL async_reaccept: got %b expected 00010", btn_level); end
        checks++; if (btn_press !== 5'b00010) begin errors++; $display("FAIL async_reaccept_press: got %b expected 00010", btn_press); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        clr       = 1'b1;
        tick1ms   = 1'b0;
        step_tick = 1'b0;
        btn_raw   = '0;
        test_reset();
        test_debounce();
        test_glitch();
        test_reversal();
        test_same_cycle();
        test_priority_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
